// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and default width.
package serial_adder_pkg;

  // Default operand width in bits.
  localparam int unsigned DEFAULT_N = 8;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [N-1:0] suma;
  logic         acarreo;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, a, b, c_in,
    input  busy, done, suma, acarreo
  );

  // Adder side: consumes operands, produces status and result.
  modport slave (
    input  start, a, b, c_in,
    output busy, done, suma, acarreo
  );

endinterface

// File: rtl/serial_adder_fa.sv
// One-bit full adder used as the single arithmetic cell of the serial adder.
module fa (
  output logic carry,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  assign sum   = a ^ b ^ c_in;
  assign carry = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB first, one bit per clock through a single full adder
// and a carry flop. Result lands in suma/acarreo with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int              CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [N-1:0]     suma_q, suma_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             acarreo_q, acarreo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_sum;
  logic             fa_carry;

  fa u_fa (
    .carry (fa_carry),
    .sum   (fa_sum),
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q)
  );

  // Next-state and datapath: load on accepted start, shift/add in RUN.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    suma_d    = suma_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    acarreo_d = acarreo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d       = bus.a;
          b_d       = bus.b;
          carry_d   = bus.c_in;
          cnt_d     = '0;
          suma_d    = '0;
          acarreo_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end else begin
          state_d   = IDLE;
        end
      end
      RUN: begin
        // New sum bit enters at the MSB so bit 0 ends up at the LSB after N shifts.
        suma_d  = {fa_sum, suma_q[N-1:1]};
        carry_d = fa_carry;
        a_d     = {1'b0, a_q[N-1:1]};
        b_d     = {1'b0, b_q[N-1:1]};
        if (cnt_q == CNT_LAST) begin
          // Counter parks at N-1 rather than wrapping.
          acarreo_d = fa_carry;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          busy_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      suma_q    <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      acarreo_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      suma_q    <= suma_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      acarreo_q <= acarreo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.suma    = suma_q;
  assign bus.acarreo = acarreo_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (N=8).
module tb_serial_adder;

  localparam int N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_adder_if #(.N(N)) bus ();

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_suma;
    logic       exp_c;
  } vec_t;

  vec_t vecs [10];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Steps negedges until done is seen; returns -1 if the budget runs out.
  task automatic wait_done(input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  // One full addition: accept, check latency, result, and hold afterwards.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] es, input logic ec);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.c_in = cin;
    @(negedge clk);
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.c_in = ~cin;
    check({tag, "_busy_run"}, bus.busy, 1'b1);
    wait_done(N + 4, cyc);
    check({tag, "_latency"}, cyc, N);
    check({tag, "_suma"}, bus.suma, es);
    check({tag, "_acarreo"}, bus.acarreo, ec);
    check({tag, "_busy_done"}, bus.busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_suma_hold"}, bus.suma, es);
    check({tag, "_acarreo_hold"}, bus.acarreo, ec);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [7:0] seen_suma;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[5] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[9] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0};

    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.c_in = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_suma", bus.suma, 8'h00);
    check("rst_acarreo", bus.acarreo, 1'b0);
    rst_n = 1'b1;

    // Table of directed vectors
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].exp_suma, vecs[i].exp_c);
    end

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.c_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h55; bus.c_in = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0; seen_suma = 8'h00;
    for (int c = 0; c < 2 * N + 2; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        seen_suma = bus.suma;
      end
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_suma", seen_suma, 8'h46);
    check("ignore_acarreo", bus.acarreo, 1'b0);
    check("ignore_idle_busy", bus.busy, 1'b0);

    // Reset during RUN aborts; first start after release accepted immediately
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.c_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_suma", bus.suma, 8'h00);
    check("abort_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1; bus.a = 8'h03; bus.b = 8'h04; bus.c_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("post_rst_busy", bus.busy, 1'b1);
    wait_done(N + 4, cyc);
    check("post_rst_latency", cyc, N);
    check("post_rst_suma", bus.suma, 8'h07);
    check("post_rst_acarreo", bus.acarreo, 1'b0);

    // start held across DONE: back-to-back operations, no IDLE cycle
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'h01; bus.c_in = 1'b0;
    @(negedge clk);
    bus.a = 8'h20; bus.b = 8'h03; bus.c_in = 1'b1;
    wait_done(N + 4, cyc);
    check("b2b_first_latency", cyc, N);
    check("b2b_first_suma", bus.suma, 8'h10);
    check("b2b_first_busy", bus.busy, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_no_idle_busy", bus.busy, 1'b1);
    check("b2b_no_idle_done", bus.done, 1'b0);
    wait_done(N + 4, cyc);
    check("b2b_spacing", cyc + 1, N + 1);
    check("b2b_second_suma", bus.suma, 8'h24);
    check("b2b_second_acarreo", bus.acarreo, 1'b0);
    @(negedge clk);
    check("b2b_end_done", bus.done, 1'b0);
    check("b2b_end_busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
